gcd_reducer: RTL and testbench
==============================

# gcd_reducer

Sequential stage directly downstream of the combinational `gcd` unit. It accepts an operand pair `u`, `v` together with their greatest common divisor `g`, and divides both operands by `g` using two lock-stepped restoring dividers. It returns the reduced (coprime) pair over a valid/ready handshake. It sits between the gcd datapath and any consumer that needs fractions in lowest terms.

## Interface
- `WIDTH`, default 8: operand, divisor and quotient width in bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: `u`/`v`/`g` are valid this cycle.
- `in_ready`  out  1: block can accept; high only in IDLE.
- `u`  in  WIDTH: dividend A (numerator).
- `v`  in  WIDTH: dividend B (denominator).
- `g`  in  WIDTH: divisor, normally `gcd(u,v)` from the gcd stage.
- `out_valid`  out  1: result registers hold a completed result.
- `out_ready`  in  1: consumer takes the result this cycle.
- `u_red`  out  WIDTH: floor(u / g).
- `v_red`  out  WIDTH: floor(v / g).
- `err`  out  1: divide-by-zero flag, set when `g == 0`; qualified by `out_valid`.

## Operation
- States: IDLE, DIV, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid`, latch `u`, `v`, `g`.
  - If `g == 0`: `u_red = 0`, `v_red = 0`, `err = 1`, go to DONE.
  - Otherwise: clear both partial remainders (WIDTH+1 bits) and both quotients, load the bit counter with WIDTH-1, clear `err`, go to DIV.
- DIV, one quotient bit per cycle per divider, MSB first:
  - `r' = {r[WIDTH-1:0], dividend[bit]}`.
  - If `r' >= g`: `r = r' - g` and the quotient bit is 1; else `r = r'` and the bit is 0.
  - Subtraction is done at WIDTH+1 bits; no wrap-around is possible.
  - When the counter reaches 0 after the final bit, go to DONE.
- DONE:
  - `out_valid = 1`; `u_red`, `v_red` and `err` are held stable.
  - On `out_ready`, go to IDLE. There is no accept in the same cycle; `in_ready` is 0 throughout DONE.
- `g` that does not divide `u`/`v` is a caller error. Quotients are still floor-correct, and no flag is raised.
- `u = 0` or `v = 0` with nonzero `g` yields quotient 0 for that operand.
- `in_valid` outside IDLE is ignored; inputs are not sampled.
- Reset has priority in every state: state → IDLE, `in_ready = 1`, `out_valid = 0`, `u_red = v_red = 0`, `err = 0`, counter and remainders cleared. An in-flight operation is discarded.

## Timing
- Accept edge = cycle 0.
- Nonzero `g`: DIV occupies cycles 1..WIDTH; `out_valid` rises at cycle WIDTH+1 (cycle 9 for WIDTH=8).
- `g == 0`: `out_valid` at cycle 1.
- Throughput: one result per WIDTH+2 cycles with `out_ready` held high; one result per 2 cycles for the `g == 0` case.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `in_ready` and `out_valid` are functions of state only and are never high together.

## Structure
- Package `gcd_pkg`:
  - `GCD_WIDTH = 8`.
  - State enum `red_state_t {IDLE, DIV, DONE}`.
  - `typedef logic [GCD_WIDTH-1:0] gcd_word_t`.
- One sub-module, `restoring_div_step`: combinational single-bit restoring step (remainder in, dividend bit, divisor → remainder out, quotient bit). Instantiated twice in the top module.
- Top module holds the FSM, counter, operand/quotient/remainder registers and handshake logic.

## Test plan
- u=100, v=20, g=20, `out_ready` high → `out_valid` at cycle 9; `u_red=5`, `v_red=1`, `err=0`; `in_ready` back high at cycle 10.
- u=0, v=0, g=0 → `out_valid` at cycle 1; `u_red=0`, `v_red=0`, `err=1`.
- u=127, v=255, g=1 → 127, 255. Then u=0, v=64, g=64 → 0, 1.
- u=76, v=64, g=4, `out_ready` low for 3 cycles after `out_valid` → 19, 16 held stable; `in_ready=0` throughout; IDLE one cycle after `out_ready`.
- u=98, v=8, g=2 accepted; `in_valid` with u=9, v=8, g=1 pulsed at cycle 3 → ignored; result 49, 4.
- Pulse `rst` at cycle 4 of u=100, v=35, g=5 → next cycle `in_ready=1`, `out_valid=0`, outputs 0. Re-issue u=100, v=35, g=5 → 20, 7.

Source files
------------

// File: rtl/gcd_reducer_pkg.sv
// Shared types for the gcd reduction stage.
// Word width, FSM states and the operand word type.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } red_state_t;

    typedef logic [GCD_WIDTH-1:0] gcd_word_t;

endpackage

// File: rtl/gcd_reducer_if.sv
// Valid/ready bundle between the gcd stage, the reducer
// and the downstream consumer of reduced fractions.
interface gcd_reducer_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] g;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] u_red;
    logic [WIDTH-1:0] v_red;
    logic             err;

    modport master (
        output in_valid,
        output u,
        output v,
        output g,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  u_red,
        input  v_red,
        input  err
    );

    modport slave (
        input  in_valid,
        input  u,
        input  v,
        input  g,
        input  out_ready,
        output in_ready,
        output out_valid,
        output u_red,
        output v_red,
        output err
    );

endinterface

// File: rtl/gcd_reducer_div_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module restoring_div_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    logic [WIDTH+1:0] wide;
    logic             ge;

    // rem_in stays below divisor, so its top bit is always zero
    // and the shifted value fits comfortably in WIDTH+1 bits.
    always_comb begin
        wide    = {rem_in, din};
        ge      = (wide >= {2'b00, divisor});
        qbit    = ge;
        rem_out = ge ? (wide[WIDTH:0] - {1'b0, divisor})
                     : wide[WIDTH:0];
    end

endmodule

// File: rtl/gcd_reducer.sv
// Divides u and v by their gcd with two lock-stepped
// restoring dividers, one quotient bit per cycle.
module gcd_reducer
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    gcd_reducer_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    red_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] u_q;
    logic [WIDTH-1:0] v_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH:0]   u_rem;
    logic [WIDTH:0]   v_rem;
    logic [WIDTH-1:0] u_quo;
    logic [WIDTH-1:0] v_quo;
    logic             err_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH:0]   u_rem_nx;
    logic [WIDTH:0]   v_rem_nx;
    logic             u_bit;
    logic             v_bit;

    restoring_div_step #(.WIDTH(WIDTH)) u_div (
        .rem_in  (u_rem),
        .din     (u_q[cnt]),
        .divisor (g_q),
        .rem_out (u_rem_nx),
        .qbit    (u_bit)
    );

    restoring_div_step #(.WIDTH(WIDTH)) v_div (
        .rem_in  (v_rem),
        .din     (v_q[cnt]),
        .divisor (g_q),
        .rem_out (v_rem_nx),
        .qbit    (v_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            u_q         <= '0;
            v_q         <= '0;
            g_q         <= '0;
            u_rem       <= '0;
            v_rem       <= '0;
            u_quo       <= '0;
            v_quo       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        u_q        <= bus.u;
                        v_q        <= bus.v;
                        g_q        <= bus.g;
                        u_rem      <= '0;
                        v_rem      <= '0;
                        u_quo      <= '0;
                        v_quo      <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.g == '0) begin
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            cnt   <= CW'(WIDTH - 1);
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    u_rem <= u_rem_nx;
                    v_rem <= v_rem_nx;
                    u_quo <= {u_quo[WIDTH-2:0], u_bit};
                    v_quo <= {v_quo[WIDTH-2:0], v_bit};
                    if (cnt == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.u_red     = u_quo;
    assign bus.v_red     = v_quo;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_gcd_reducer.sv
// Bench for gcd_reducer: vector table, hand-written corner
// sequences and random pairs against an arithmetic model.
module tb_gcd_reducer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    gcd_reducer_if #(.WIDTH(W)) bus ();

    gcd_reducer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int u, v, g;
        int eu, ev, eerr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act,
                       input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle count is the index of the cycle in which out_valid is
    // first seen, with the accept edge being cycle 0.
    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!bus.out_valid) chk("timeout out_valid", 0, 1);
    endtask

    task automatic issue(input int u, input int v, input int g);
        chk("in_ready before accept", int'(bus.in_ready), 1);
        bus.u = W'(u);
        bus.v = W'(v);
        bus.g = W'(g);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input int u, input int v,
                       input int g, input int stall);
        int cyc, eu, ev, ee, el;
        ee = (g == 0) ? 1 : 0;
        eu = (g == 0) ? 0 : u / g;
        ev = (g == 0) ? 0 : v / g;
        el = (g == 0) ? 1 : W + 1;
        bus.out_ready = (stall == 0);
        issue(u, v, g);
        wait_valid(1, cyc);
        chk({tag, " latency"}, cyc, el);
        chk({tag, " u_red"}, int'(bus.u_red), eu);
        chk({tag, " v_red"}, int'(bus.v_red), ev);
        chk({tag, " err"}, int'(bus.err), ee);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, " held valid"}, int'(bus.out_valid), 1);
            chk({tag, " held in_ready"}, int'(bus.in_ready), 0);
            chk({tag, " held u_red"}, int'(bus.u_red), eu);
            chk({tag, " held v_red"}, int'(bus.v_red), ev);
        end
        bus.out_ready = 1'b1;
        tick();
        chk({tag, " in_ready after"}, int'(bus.in_ready), 1);
        chk({tag, " valid after"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int cyc, u, v, g;
        vecs[0]  = '{100,  20,  20,   5,   1, 0};
        vecs[1]  = '{  0,   0,   0,   0,   0, 1};
        vecs[2]  = '{127, 255,   1, 127, 255, 0};
        vecs[3]  = '{  0,  64,  64,   0,   1, 0};
        vecs[4]  = '{ 76,  64,   4,  19,  16, 0};
        vecs[5]  = '{ 98,   8,   2,  49,   4, 0};
        vecs[6]  = '{100,  35,   5,  20,   7, 0};
        vecs[7]  = '{255, 255, 255,   1,   1, 0};
        vecs[8]  = '{200,   3,   7,  28,   0, 0};
        vecs[9]  = '{  5,   9,   0,   0,   0, 1};
        vecs[10] = '{255,   0,   1, 255,   0, 0};
        vecs[11] = '{ 17,  13, 200,   0,   0, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.u = '0;
        bus.v = '0;
        bus.g = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset u_red", int'(bus.u_red), 0);
        chk("reset v_red", int'(bus.v_red), 0);
        chk("reset err", int'(bus.err), 0);

        foreach (vecs[i]) begin
            bus.out_ready = 1'b1;
            issue(vecs[i].u, vecs[i].v, vecs[i].g);
            wait_valid(1, cyc);
            chk($sformatf("vec%0d latency", i), cyc,
                vecs[i].g == 0 ? 1 : W + 1);
            chk($sformatf("vec%0d u_red", i),
                int'(bus.u_red), vecs[i].eu);
            chk($sformatf("vec%0d v_red", i),
                int'(bus.v_red), vecs[i].ev);
            chk($sformatf("vec%0d err", i),
                int'(bus.err), vecs[i].eerr);
            tick();
            chk($sformatf("vec%0d in_ready after", i),
                int'(bus.in_ready), 1);
        end

        run("stall3", 76, 64, 4, 3);

        bus.out_ready = 1'b1;
        issue(98, 8, 2);
        tick();
        tick();
        bus.u = 8'd9;
        bus.v = 8'd8;
        bus.g = 8'd1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(4, cyc);
        chk("ignore latency", cyc, W + 1);
        chk("ignore u_red", int'(bus.u_red), 49);
        chk("ignore v_red", int'(bus.v_red), 4);
        tick();
        chk("ignore idle", int'(bus.in_ready), 1);

        issue(100, 35, 5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst in_ready", int'(bus.in_ready), 1);
        chk("midrst out_valid", int'(bus.out_valid), 0);
        chk("midrst u_red", int'(bus.u_red), 0);
        chk("midrst v_red", int'(bus.v_red), 0);
        chk("midrst err", int'(bus.err), 0);
        run("reissue", 100, 35, 5, 0);

        for (int n = 0; n < 40; n++) begin
            u = int'($urandom_range(0, 255));
            v = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) g = 0;
            else g = int'($urandom_range(1, 255));
            if ($urandom_range(0, 1) == 1 && g > 0) begin
                u = (u % (256 / g)) * g;
                v = (v % (256 / g)) * g;
            end
            run($sformatf("rnd%0d", n), u, v, g,
                int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
